// File: rtl/grn_ctrl_pkg.sv
// Shared constants for the ingress dispatcher: FSM state codes, array defaults
// and the position of the broadcast flag bit.
package grn_ctrl_pkg;

  localparam int NUM_PE_DEF = 32;
  localparam int ID_W_DEF   = 5;
  localparam int DATA_W_DEF = 32;

  // MSB of a word marks a configuration broadcast when that mode is built in.
  localparam int BCAST_BIT  = DATA_W_DEF - 1;

  localparam logic [1:0] DISP_IDLE = 2'd0;
  localparam logic [1:0] DISP_WAIT = 2'd1;
  localparam logic [1:0] DISP_SEL  = 2'd2;

endpackage

// File: rtl/input_dispatcher_rr_select.sv
// Combinational round-robin picker: the first free PE at or after ptr, wrapping
// from NUM_PE-1 to 0, found by rotate / priority-encode / unrotate.
module rr_select
  import grn_ctrl_pkg::*;
#(
  parameter int NUM_PE = NUM_PE_DEF,
  parameter int ID_W   = ID_W_DEF
) (
  input  logic [NUM_PE-1:0] free,
  input  logic [ID_W-1:0]   ptr,
  output logic              hit,
  output logic [ID_W-1:0]   idx
);

  logic [NUM_PE-1:0] rot;
  logic [ID_W-1:0]   off;
  logic [ID_W:0]     sum;

  // NOTE: every variable gets a default at the top of always_comb, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    rot = NUM_PE'({free, free} >> ptr);
    hit = 1'b0;
    off = '0;
    // Descending scan so the lowest set bit of the rotated mask wins.
    for (int i = NUM_PE - 1; i >= 0; i--) begin
      if (rot[i]) begin
        hit = 1'b1;
        off = ID_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (ID_W + 1)'(NUM_PE)) begin
      sum = sum - (ID_W + 1)'(NUM_PE);
    end
    idx = sum[ID_W-1:0];
  end

endmodule

// File: rtl/input_dispatcher_rr.sv
// Ingress scheduler: pops one word from the shared FIFO and writes it to the next
// non-full PE queue in round-robin order. INPUT_DISPATCH_BROADCAST_EN adds broadcast.
module input_dispatcher_rr
  import grn_ctrl_pkg::*;
#(
  parameter int NUM_PE = NUM_PE_DEF,
  parameter int ID_W   = ID_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fifo_in_empty,
  input  logic [DATA_W-1:0] fifo_in_data,
  output logic              fifo_in_rd_en,
  input  logic [NUM_PE-1:0] pe_full,
  output logic [NUM_PE-1:0] pe_wr_en,
  output logic [DATA_W-1:0] pe_data,
  output logic              busy,
  output logic [31:0]       dispatch_cnt
);

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] pe_data_q, pe_data_d;
  logic              rd_en_q, rd_en_d;
  logic [NUM_PE-1:0] wr_en_q, wr_en_d;
  logic [31:0]       cnt_q, cnt_d;

  logic              hit;
  logic [ID_W-1:0]   idx;
  logic              is_bcast;

  rr_select #(
    .NUM_PE (NUM_PE),
    .ID_W   (ID_W)
  ) u_rr_select (
    .free (~pe_full),
    .ptr  (ptr_q),
    .hit  (hit),
    .idx  (idx)
  );

`ifdef INPUT_DISPATCH_BROADCAST_EN
  localparam int BcastPos = BCAST_BIT + DATA_W - DATA_W_DEF;
  assign is_bcast = data_q[BcastPos];
`else
  assign is_bcast = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    pe_data_d = pe_data_q;
    cnt_d     = cnt_q;
    rd_en_d   = 1'b0;
    wr_en_d   = '0;
    case (state_q)
      DISP_IDLE: begin
        if (start && !fifo_in_empty) begin
          rd_en_d = 1'b1;
          state_d = DISP_WAIT;
        end
      end
      // Capture regardless of start so a popped word is never dropped.
      DISP_WAIT: begin
        data_d  = fifo_in_data;
        state_d = DISP_SEL;
      end
      DISP_SEL: begin
        if (start) begin
          if (is_bcast) begin
            if (!(|pe_full)) begin
              wr_en_d   = '1;
              pe_data_d = data_q;
              cnt_d     = cnt_q + 32'd1;
              state_d   = DISP_IDLE;
            end
          end else if (hit) begin
            wr_en_d   = {{(NUM_PE - 1){1'b0}}, 1'b1} << idx;
            pe_data_d = data_q;
            ptr_d     = (idx == ID_W'(NUM_PE - 1)) ? '0 : idx + ID_W'(1);
            cnt_d     = cnt_q + 32'd1;
            state_d   = DISP_IDLE;
          end
        end
      end
      default: state_d = DISP_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DISP_IDLE;
      ptr_q     <= '0;
      data_q    <= '0;
      pe_data_q <= '0;
      cnt_q     <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      data_q    <= data_d;
      pe_data_q <= pe_data_d;
      cnt_q     <= cnt_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
    end
  end

  assign fifo_in_rd_en = rd_en_q;
  assign pe_wr_en      = wr_en_q;
  assign pe_data       = pe_data_q;
  assign dispatch_cnt  = cnt_q;
  assign busy          = (state_q != DISP_IDLE);

endmodule

// File: tb/tb_input_dispatcher_rr.sv
// Self-checking bench for input_dispatcher_rr: directed scenarios plus random
// traffic, checked every cycle against a transaction-timing reference model.
module tb_input_dispatcher_rr;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          fifo_in_empty;
  logic [31:0]   fifo_in_data;
  logic          fifo_in_rd_en;
  logic [N-1:0]  pe_full;
  logic [N-1:0]  pe_wr_en;
  logic [31:0]   pe_data;
  logic          busy;
  logic [31:0]   dispatch_cnt;

  always #5 clk = ~clk;

  input_dispatcher_rr dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .fifo_in_empty (fifo_in_empty),
    .fifo_in_data  (fifo_in_data),
    .fifo_in_rd_en (fifo_in_rd_en),
    .pe_full       (pe_full),
    .pe_wr_en      (pe_wr_en),
    .pe_data       (pe_data),
    .busy          (busy),
    .dispatch_cnt  (dispatch_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] fifo_q[$];

  // Reference model: a word is either pending or not; a pending word may be
  // written from the second edge after its pop, whenever start is high and a
  // suitable PE is free at that edge.
  bit          m_pend  = 1'b0;
  int          m_ready = 0;
  int          m_ptr   = 0;
  logic [31:0] m_word  = '0;
  logic [31:0] m_data  = '0;
  logic [31:0] m_cnt   = '0;
  logic [N-1:0] m_wr   = '0;
  bit          m_rd    = 1'b0;
  int          edge_n  = 0;

  logic [N-1:0] wr_log[$];
  int           wr_edge[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic int first_free(input logic [N-1:0] full, input int from);
    for (int k = 0; k < N; k++) begin
      if (!full[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic refresh_fifo();
    fifo_in_empty = (fifo_q.size() == 0);
    fifo_in_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    refresh_fifo();
  endtask

  task automatic tick();
    bit           s_rst, s_start, s_emp, s_rd, bc;
    logic [N-1:0] s_full;
    int           tgt;
    s_rst   = rst;
    s_start = start;
    s_emp   = fifo_in_empty;
    s_rd    = fifo_in_rd_en;
    s_full  = pe_full;
    @(posedge clk);
    edge_n++;
    m_rd = 1'b0;
    m_wr = '0;
    if (s_rst) begin
      m_pend = 1'b0;
      m_ptr  = 0;
      m_cnt  = '0;
      m_data = '0;
    end else if (!m_pend) begin
      if (s_start && !s_emp) begin
        m_rd    = 1'b1;
        m_pend  = 1'b1;
        m_ready = edge_n + 2;
        m_word  = fifo_q[0];
      end
    end else if (edge_n >= m_ready && s_start) begin
      bc = 1'b0;
`ifdef INPUT_DISPATCH_BROADCAST_EN
      bc = m_word[31];
`endif
      if (bc) begin
        if (s_full == '0) m_wr = '1;
      end else begin
        tgt = first_free(s_full, m_ptr);
        if (tgt >= 0) begin
          m_wr[tgt] = 1'b1;
          m_ptr     = (tgt + 1) % N;
        end
      end
      if (m_wr != '0) begin
        m_data = m_word;
        m_cnt  = m_cnt + 32'd1;
        m_pend = 1'b0;
      end
    end
    #1;
    if (s_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh_fifo();
    check("rd_en",    32'(fifo_in_rd_en), 32'(m_rd));
    check("wr_en",    32'(pe_wr_en),      32'(m_wr));
    check("pe_data",  pe_data,            m_data);
    check("disp_cnt", dispatch_cnt,       m_cnt);
    check("busy",     32'(busy),          32'(m_pend));
    if (pe_wr_en != '0) begin
      wr_log.push_back(pe_wr_en);
      wr_edge.push_back(edge_n);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while ((m_pend || fifo_q.size() > 0) && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(k < budget), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          base, k;
    logic [31:0] w;
    rst     = 1'b1;
    start   = 1'b0;
    pe_full = '0;
    refresh_fifo();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // 1: four words, all free -> PE0..PE3, three cycles apart.
    start = 1'b1;
    base  = wr_log.size();
    for (int i = 0; i < 4; i++) push(32'h0000_1000 + 32'(i));
    drain("t1_drain", 40);
    check("t1_cnt", dispatch_cnt, 32'd4);
    for (int i = 0; i < 4; i++) check("t1_pe", 32'(wr_log[base+i]), 32'd1 << i);
    for (int i = 1; i < 4; i++) check("t1_gap", 32'(wr_edge[base+i] - wr_edge[base+i-1]), 32'd3);

    // 2: advance ptr to 30, then PE31 and PE0 full.
    for (int i = 0; i < 26; i++) push(32'h0000_2000 + 32'(i));
    drain("t2_fill", 200);
    pe_full = 32'h8000_0001;
    base    = wr_log.size();
    push(32'h0000_3030);
    push(32'h0000_3031);
    drain("t2_drain", 40);
    check("t2_pe30", 32'(wr_log[base]),   32'h4000_0000);
    check("t2_pe1",  32'(wr_log[base+1]), 32'h0000_0002);
    pe_full = '0;

    // 3: all full parks in SEL; freeing PE7 alone dispatches next cycle.
    pe_full = '1;
    w       = 32'h0C0F_FEE1;
    push(w);
    base = wr_log.size();
    repeat (12) tick();
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_nowr", 32'(wr_log.size() - base), 32'd0);
    pe_full = ~(32'h0000_0080);
    tick();
    check("t3_pe7",  32'(pe_wr_en), 32'h0000_0080);
    check("t3_data", pe_data, w);
    pe_full = '0;
    tick();

    // 4: start dropped while the pop strobe is up; the word survives once.
    w = 32'h0000_4444;
    push(w);
    k = 0;
    while (!fifo_in_rd_en && k < 10) begin
      tick();
      k++;
    end
    check("t4_pop", 32'(fifo_in_rd_en), 32'd1);
    start = 1'b0;
    base  = wr_log.size();
    repeat (6) tick();
    check("t4_park", 32'(busy), 32'd1);
    check("t4_nowr", 32'(wr_log.size() - base), 32'd0);
    start = 1'b1;
    repeat (6) tick();
    check("t4_once", 32'(wr_log.size() - base), 32'd1);
    check("t4_data", pe_data, w);

    // 5: reset while parked in SEL clears everything, ptr back to 0.
    pe_full = '1;
    push(32'h0000_5555);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_wr",   32'(pe_wr_en),      32'd0);
    check("t5_rd",   32'(fifo_in_rd_en), 32'd0);
    check("t5_data", pe_data,            32'd0);
    check("t5_cnt",  dispatch_cnt,       32'd0);
    check("t5_busy", 32'(busy),          32'd0);
    pe_full = '0;
    base    = wr_log.size();
    push(32'h0000_5556);
    drain("t5_drain", 40);
    check("t5_pe0", 32'(wr_log[base]), 32'd1);

    // 6: flagged word with PE3 full (ptr is 1 here).
    pe_full = 32'h0000_0008;
    base    = wr_log.size();
    push(32'h8000_00AB);
    repeat (8) tick();
`ifdef INPUT_DISPATCH_BROADCAST_EN
    check("t6_wait", 32'(wr_log.size() - base), 32'd0);
    pe_full = '0;
    tick();
    check("t6_bcast", 32'(pe_wr_en), 32'hFFFF_FFFF);
    check("t6_data",  pe_data, 32'h8000_00AB);
    push(32'h0000_0011);
    drain("t6_drain", 40);
    check("t6_ptr", 32'(wr_log[wr_log.size()-1]), 32'h0000_0002);
`else
    check("t6_one",  32'(wr_log.size() - base), 32'd1);
    check("t6_ptr",  32'(wr_log[base]), 32'h0000_0002);
    check("t6_data", pe_data, 32'h8000_00AB);
    pe_full = '0;
`endif

    // Random traffic, back-pressure and occasional reset.
    for (int c = 0; c < 1500; c++) begin
      rst   = ($urandom_range(0, 399) == 0);
      start = ($urandom_range(0, 99) < 85);
      if (fifo_q.size() < 4 && $urandom_range(0, 9) < 3) push($urandom);
      case ($urandom_range(0, 19))
        0:       pe_full = '1;
        1, 2:    pe_full = '0;
        default: pe_full = N'($urandom & $urandom & $urandom);
      endcase
      tick();
    end
    rst     = 1'b0;
    start   = 1'b1;
    pe_full = '0;
    drain("final_drain", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
